dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 77 +++++++
 tb/tb_dmem_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: zero-wait data memory with CLEAR sweep, posted 1-entry store buffer and load forwarding.
// Define DMEM_RANGECHK_EN to enable out-of-range detection (ERR/ERR_ADDR); otherwise addresses wrap.
module dmem_responder #(
  parameter int AW = 10,
  parameter int DEPTH = 2**AW
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DREQ,
  input  logic        DRW,
  input  logic [29:0] DADDR,
  input  logic [31:0] DWDATA,
  output logic [31:0] DRDATA,
  output logic        READY,
  output logic        ERR,
  output logic [29:0] ERR_ADDR
);
  typedef enum logic {CLEAR, RUN} state_e;
  state_e state_q;
  logic [AW-1:0] ptr_q, wb_addr_q, idx;
  logic wb_valid_q, err_q, run, in_rng, st;
  logic [31:0] wb_data_q;
  logic [29:0] err_addr_q;
  logic [31:0] mem_q [DEPTH];
  assign idx = DADDR[AW-1:0];
  assign run = state_q == RUN;
`ifdef DMEM_RANGECHK_EN
  logic oor;
  assign in_rng = ~|DADDR[29:AW];
  assign oor = run & DREQ & ~in_rng;
`else
  logic unused_hi;
  assign in_rng = 1'b1;
  assign unused_hi = ^DADDR[29:AW];
`endif
  assign st = run & DREQ & DRW & in_rng;
  // the pending buffered store is newer than the array, so it wins on a match
  assign DRDATA = (run && DREQ && !DRW && in_rng)
                ? ((wb_valid_q && wb_addr_q == idx) ? wb_data_q : mem_q[idx]) : '0;
  assign READY = run;
  assign ERR = err_q;
  assign ERR_ADDR = err_addr_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR;
      ptr_q <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      err_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (state_q == CLEAR) begin
        ptr_q <= ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH-1)) state_q <= RUN;
      end
      wb_valid_q <= st;
      if (st) begin
        wb_addr_q <= idx;
        wb_data_q <= DWDATA;
      end
`ifdef DMEM_RANGECHK_EN
      if (oor) begin
        err_q <= 1'b1;
        if (!err_q) err_addr_q <= DADDR;
      end
`endif
    end
  end
  // a reset edge drops the buffered commit; CLEAR re-zeroes everything anyway
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_q == CLEAR) mem_q[ptr_q] <= '0;
      else if (wb_valid_q) mem_q[wb_addr_q] <= wb_data_q;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder (AW=4) against a flat memory model.
// Honors DMEM_RANGECHK_EN to select the range-check or wrap scenarios.
module tb_dmem_responder;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  logic CLK = 0, RST = 0, DREQ = 0, DRW = 0;
  logic [29:0] DADDR = '0;
  logic [31:0] DWDATA = '0;
  logic [31:0] DRDATA;
  logic READY, ERR;
  logic [29:0] ERR_ADDR;
  int checks = 0, fails = 0;
  logic [31:0] ref_mem [DEPTH];
  logic ref_err;
  logic [29:0] ref_eaddr;

  dmem_responder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
    .DRDATA(DRDATA), .READY(READY), .ERR(ERR), .ERR_ADDR(ERR_ADDR)
  );

  always #5 CLK = ~CLK;

  function automatic logic in_rng(input logic [29:0] a);
`ifdef DMEM_RANGECHK_EN
    return a[29:AW] == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    return in_rng(a) ? ref_mem[a[AW-1:0]] : 32'h0;
  endfunction

  // one access in RUN: samples DRDATA before the edge, then updates the model
  task automatic op(input logic rw, input logic [29:0] a, input logic [31:0] d, output logic [31:0] rd);
    DREQ = 1; DRW = rw; DADDR = a; DWDATA = d;
    @(negedge CLK);
    rd = DRDATA;
    if (!in_rng(a)) begin
      if (!ref_err) ref_eaddr = a;
      ref_err = 1;
    end else if (rw) ref_mem[a[AW-1:0]] = d;
    @(posedge CLK); #1;
    DREQ = 0; DRW = 0;
  endtask

  // pulse reset, then hammer requests during CLEAR; reports CLEAR length and any leak
  task automatic rst_clear(output int cnt, output logic bad);
    RST = 1;
    @(posedge CLK); #1;
    RST = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_err = 0; ref_eaddr = '0;
    cnt = 0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      DREQ = 1; DRW = (i % 2 == 0); DADDR = DRW ? 30'h3F : 30'h0; DWDATA = '1;
      @(negedge CLK);
      if (READY === 1'b1) break;
      cnt++;
      if (DRDATA !== 32'h0 || ERR !== 1'b0) bad = 1;
      @(posedge CLK); #1;
    end
    DREQ = 0; DRW = 0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    int cnt; logic bad; logic [31:0] rd;
    rst_clear(cnt, bad);
    checks++; if (cnt !== 16) begin fails++; $display("FAIL clear_len: got %0d want 16", cnt); end
    checks++; if (bad !== 1'b0) begin fails++; $display("FAIL clear_quiet: DRDATA/ERR nonzero during CLEAR"); end
    checks++; if (READY !== 1'b1) begin fails++; $display("FAIL ready_after: got %b want 1", READY); end
    checks++; if (ERR !== 1'b0 || ERR_ADDR !== 30'h0) begin fails++; $display("FAIL err_reset: got %b/%h want 0/0", ERR, ERR_ADDR); end
    for (int a = 0; a < DEPTH; a++) begin
      op(0, 30'(a), 32'h0, rd);
      checks++; if (rd !== 32'h0) begin fails++; $display("FAIL clear_load[%0d]: got %h want 0", a, rd); end
    end
  endtask

  task automatic test_forward;
    logic [31:0] rd;
    op(1, 30'd5, 32'hDEADBEEF, rd);
    checks++; if (rd !== 32'h0) begin fails++; $display("FAIL store_rd0: got %h want 0", rd); end
    op(0, 30'd5, 32'h0, rd);
    checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL fwd_load: got %h want deadbeef", rd); end
    @(negedge CLK);
    checks++; if (DRDATA !== 32'h0) begin fails++; $display("FAIL idle_rd0: got %h want 0", DRDATA); end
    @(posedge CLK); #1;
    op(0, 30'd5, 32'h0, rd);
    checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL array_load: got %h want deadbeef", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    logic [31:0] exp [3] = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) op(1, 30'(i + 1), exp[i], rd);
    for (int i = 0; i < 3; i++) begin
      op(0, 30'(i + 1), 32'h0, rd);
      checks++; if (rd !== exp[i]) begin fails++; $display("FAIL b2b[%0d]: got %h want %h", i + 1, rd, exp[i]); end
    end
  endtask

`ifdef DMEM_RANGECHK_EN
  task automatic test_range;
    logic [31:0] rd;
    op(1, 30'h20, 32'hCAFE0001, rd);
    op(1, 30'h40, 32'hCAFE0002, rd);
    checks++; if (ERR !== 1'b1) begin fails++; $display("FAIL err_set: got %b want 1", ERR); end
    checks++; if (ERR_ADDR !== 30'h20) begin fails++; $display("FAIL err_addr: got %h want 20", ERR_ADDR); end
    op(0, 30'h20, 32'h0, rd);
    checks++; if (rd !== 32'h0) begin fails++; $display("FAIL oor_load: got %h want 0", rd); end
    op(0, 30'h0, 32'h0, rd);
    checks++; if (rd !== ref_rd(30'h0)) begin fails++; $display("FAIL oor_nowrite: got %h want %h", rd, ref_rd(30'h0)); end
  endtask
`else
  task automatic test_wrap;
    logic [31:0] rd;
    op(1, 30'h12, 32'hAB, rd);
    op(0, 30'h02, 32'h0, rd);
    checks++; if (rd !== 32'hAB) begin fails++; $display("FAIL wrap_load: got %h want ab", rd); end
    checks++; if (ERR !== 1'b0 || ERR_ADDR !== 30'h0) begin fails++; $display("FAIL wrap_err: got %b/%h want 0/0", ERR, ERR_ADDR); end
  endtask
`endif

  task automatic test_random;
    logic [31:0] rd, exp;
    logic [29:0] a;
    logic rw;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        DREQ = 0; DRW = 1'($urandom); DADDR = 30'($urandom); DWDATA = $urandom;
        @(negedge CLK);
        checks++; if (DRDATA !== 32'h0) begin fails++; $display("FAIL rnd_idle[%0d]: got %h want 0", n, DRDATA); end
        @(posedge CLK); #1;
        continue;
      end
      rw = 1'($urandom);
`ifdef DMEM_RANGECHK_EN
      a = 30'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 7) == 0) begin
        a = 30'($urandom);
        a[AW] = 1'b1;
      end
`else
      a = 30'($urandom);
`endif
      exp = rw ? 32'h0 : ref_rd(a);
      op(rw, a, $urandom, rd);
      checks++; if (rd !== exp) begin fails++; $display("FAIL rnd_rd[%0d] a=%h: got %h want %h", n, a, rd, exp); end
      checks++; if (ERR !== ref_err || ERR_ADDR !== ref_eaddr) begin
        fails++; $display("FAIL rnd_err[%0d]: got %b/%h want %b/%h", n, ERR, ERR_ADDR, ref_err, ref_eaddr);
      end
    end
  endtask

  task automatic test_reset_mid;
    int cnt; logic bad; logic [31:0] rd;
    op(1, 30'd7, 32'h77777777, rd);
    rst_clear(cnt, bad);
    checks++; if (cnt !== 16) begin fails++; $display("FAIL mid_clear_len: got %0d want 16", cnt); end
    op(0, 30'd7, 32'h0, rd);
    checks++; if (rd !== 32'h0) begin fails++; $display("FAIL mid_load7: got %h want 0", rd); end
    checks++; if (ERR !== 1'b0) begin fails++; $display("FAIL mid_err: got %b want 0", ERR); end
  endtask

  initial begin
    @(posedge CLK); #1;
    test_reset;
    test_forward;
    test_back_to_back;
`ifdef DMEM_RANGECHK_EN
    test_range;
`else
    test_wrap;
`endif
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
